// File: rtl/rtc_bus_arbiter.sv
// Three-requester arbiter in front of a single RTC register bus, with a 9-bit transaction watchdog.
// Define ARB_ROUND_ROBIN_EN for rotating priority; the default is fixed priority 0 > 1 > 2.
module rtc_bus_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [7:0] dir0,
  input  logic [7:0] dir1,
  input  logic [7:0] dir2,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       bus_done,
  input  logic [7:0] bus_rdata,
  output logic       bus_start,
  output logic       bus_wr,
  output logic       bus_rd,
  output logic [7:0] bus_dir,
  output logic [7:0] bus_data,
  output logic [2:0] grant,
  output logic [2:0] done,
  output logic [7:0] rd_data,
  output logic       timeout
);
  typedef enum logic [1:0] {IDLE, GRANT, BUSY, DONE} state_t;

  state_t     state, state_nxt;
  logic [2:0] own_oh;
  logic       is_rd, to_flag, wd_exp;
  logic [8:0] wdog;
  logic [1:0] ptr, win;
  logic [7:0] sel_dir, sel_data;

  assign wd_exp = (wdog == 9'd511);

  function automatic logic [1:0] rot(input logic [1:0] p, input logic [1:0] i);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, i};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // scan from ptr upward; the lowest offset with a request wins
  always_comb begin
    win = 2'd0;
    for (int i = 2; i >= 0; i--)
      if (req[rot(ptr, 2'(i))]) win = rot(ptr, 2'(i));
  end

  always_comb begin
    sel_dir  = dir2;
    sel_data = 8'h00;
    case (win)
      2'd0:    begin sel_dir = dir0; sel_data = data0; end
      2'd1:    begin sel_dir = dir1; sel_data = data1; end
      default: ;
    endcase
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    ptr <= 2'd0;
    else if (state == IDLE && |req) ptr <= (win == 2'd2) ? 2'd0 : win + 2'd1;
  end
`else
  assign ptr = 2'd0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (|req) state_nxt = GRANT;
      GRANT: state_nxt = BUSY;
      BUSY:  if (bus_done || wd_exp) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant     = (state != IDLE) ? own_oh : 3'b000;
    done      = (state == DONE) ? own_oh : 3'b000;
    bus_start = (state == BUSY) && (wdog == 9'd0);
    bus_wr    = (state != IDLE) && !is_rd;
    bus_rd    = (state != IDLE) && is_rd;
    timeout   = (state == DONE) && to_flag;
  end

  // transaction is captured once in IDLE; later requester activity cannot disturb it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      own_oh   <= 3'b000;
      is_rd    <= 1'b0;
      bus_dir  <= 8'h00;
      bus_data <= 8'h00;
      rd_data  <= 8'h00;
      wdog     <= 9'd0;
      to_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          own_oh   <= 3'b001 << win;
          is_rd    <= (win == 2'd2);
          bus_dir  <= sel_dir;
          bus_data <= sel_data;
        end
        GRANT: begin
          wdog    <= 9'd0;
          to_flag <= 1'b0;
        end
        BUSY: begin
          wdog <= wdog + 9'd1;
          if (bus_done) begin
            if (is_rd) rd_data <= bus_rdata;
          end else if (wd_exp) begin
            to_flag <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/rtc_bus_arbiter.md
RTC_BUS_ARBITER -- requirements
Module: rtc_bus_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; low forces the reset state immediately.
REQ-004 req  in  3  request per requester: bit0 chronometer control, bit1 time/date set, bit2 periodic refresh read; level, held until done.
REQ-005 dir0, dir1, dir2  in  8 each  RTC register address from requester 0/1/2.
REQ-006 data0, data1  in  8 each  write data from requesters 0/1; requester 2 is read-only.
REQ-007 bus_done  in  1  RTC interface completion pulse.
REQ-008 bus_rdata  in  8  RTC read data, valid when bus_done=1.
REQ-009 bus_start  out  1  one-cycle transaction start pulse to RTC interface.
REQ-010 bus_wr, bus_rd  out  1 each  transaction type; level, held for the whole transaction.
REQ-011 bus_dir, bus_data  out  8 each  latched address/data of the granted requester.
REQ-012 grant  out  3  one-hot owner; all zero when idle.
REQ-013 done  out  3  one-cycle completion pulse to the owner.
REQ-014 rd_data  out  8  last successfully read byte.
REQ-015 timeout  out  1  one-cycle pulse when a transaction is aborted.

Function
REQ-016 The FSM SHALL have states IDLE, GRANT, BUSY and DONE.
- IDLE->GRANT when any req bit is 1; else stay.
- GRANT->BUSY unconditionally.
- BUSY->DONE on bus_done=1 or on timeout.
- DONE->IDLE unconditionally.
REQ-017 In IDLE, arbitration SHALL pick the winner per REQ-030/031; grant is set one-hot on entry to GRANT and held through DONE.
REQ-018 On entry to GRANT, the block SHALL latch bus_dir, bus_data and the type: write for owners 0/1, read for owner 2; bus_data=0 for reads.
REQ-019 bus_start SHALL pulse for exactly the first BUSY cycle, i.e. 2 cycles after req is sampled in IDLE; bus_wr/bus_rd SHALL be high through all BUSY cycles.
REQ-020 Requester inputs changing after GRANT SHALL NOT affect the latched transaction; req dropping mid-transaction SHALL NOT abort it.
REQ-021 bus_done SHALL be sampled only in BUSY; in IDLE, GRANT or DONE it is ignored.
REQ-022 For a read, rd_data SHALL load bus_rdata on the cycle bus_done=1 in BUSY, and hold until the next successful read.
REQ-023 A 9-bit watchdog SHALL clear on GRANT and increment each BUSY cycle.
- At count 511 with no bus_done: go to DONE, pulse timeout with done, leave rd_data unchanged.
- bus_done on the count-511 cycle wins; it is not a timeout.
REQ-024 done[owner] SHALL pulse in DONE; grant clears, and bus_wr/bus_rd drop on return to IDLE.
REQ-025 A req still high in IDLE SHALL be re-arbitrated, giving a minimum of 4 cycles per transaction excluding bus wait.

Reset
REQ-026 reset low SHALL force state IDLE and clear the watchdog.
REQ-027 reset low SHALL force every output to 0, including grant, done, bus_start, bus_wr, bus_rd, bus_dir, bus_data, rd_data and timeout.
REQ-028 reset asserted mid-transaction SHALL drop the transaction with no done pulse.
REQ-029 After release, the first arbitration SHALL occur on the first rising edge with reset high.

Configuration
REQ-030 With ARB_ROUND_ROBIN_EN defined, priority SHALL rotate.
- The requester after the last owner (mod 3) has highest priority.
- The pointer resets to requester 0.
REQ-031 Without ARB_ROUND_ROBIN_EN, priority SHALL be fixed: 0 > 1 > 2.

Verification
REQ-032 req=001, dir0=0x0F, data0=0x05, bus_done 10 cycles after bus_start -> grant=001 and bus_start 2 cycles after req; bus_wr=1, bus_dir=0x0F, bus_data=0x05; done=001 one cycle after bus_done.
REQ-033 req=100, dir2=0x21, bus_rdata=0x37 at bus_done -> bus_rd=1, rd_data=0x37, done=100.
REQ-034 req=111 held for 3 transactions -> fixed priority grants 001,001,001; round robin grants 001,010,100.
REQ-035 req=010, bus_done never asserted -> timeout and done=010 pulse together 511 BUSY cycles after bus_start; rd_data unchanged.
REQ-036 reset low during BUSY -> all outputs 0 asynchronously, no done; after release with req=001 -> new grant=001 sequence.
REQ-037 bus_done pulsed while IDLE, and dir0 changed during BUSY -> no state change, bus_dir keeps its latched value.
